univ_shift_reg_ser: RTL and testbench

//   Parametrised successor of the universal shift register. Adds multi-bit

---
 rtl/univ_shift_reg_ser.sv | 74 +++++++
 tb/tb_univ_shift_reg_ser.sv | 121 ++++++++++++
 2 files changed

// File: rtl/univ_shift_reg_ser.sv
// univ_shift_reg_ser: universal shift/rotate register with handshaked LSB-first serial burst
module univ_shift_reg_ser #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [2:0]   ctrl,
  input  logic [W-1:0] amt,
  input  logic         si,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         so,
  output logic         so_valid,
  input  logic         so_ready,
  output logic         busy,
  output logic         done
);
  typedef enum logic {IDLE, SER} state_t;
  state_t state;
  logic [N-1:0] r_reg;
  logic [N-1:0] op_res;
  logic [W-1:0] cnt;
  logic [2*N-1:0] rol_w, ror_w;
  assign rol_w = {r_reg, r_reg} << amt;
  assign ror_w = {r_reg, r_reg} >> amt;
  assign busy = state == SER;
  assign so_valid = busy;
  assign so = busy & r_reg[0];
  assign q = r_reg;
  // Result of the single-cycle operation selected by ctrl; rotates come from a doubled word.
  always_comb begin
    op_res = r_reg;
    case (ctrl)
      3'b001: op_res = (r_reg << amt) | (si ? ~({N{1'b1}} << amt) : '0);
      3'b010: op_res = (r_reg >> amt) | (si ? ~({N{1'b1}} >> amt) : '0);
      3'b011: op_res = $signed(r_reg) >>> amt;
      3'b100: op_res = rol_w[2*N-1:N];
      3'b101: op_res = ror_w[N-1:0];
      3'b110: op_res = d;
      default: op_res = r_reg;
    endcase
  end
  // Control FSM: commands in IDLE, one shift per accepted serial bit in SER.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_reg <= '0;
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (en) begin
          if (ctrl == 3'b111) begin
            r_reg <= d;
            cnt   <= '0;
            state <= SER;
          end else r_reg <= op_res;
        end
        SER: if (so_ready) begin
          r_reg <= {1'b0, r_reg[N-1:1]};
          cnt   <= cnt + 1'b1;
          if (cnt == W'(N-1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_univ_shift_reg_ser.sv
// tb_univ_shift_reg_ser: scoreboard bench for the universal shift register with serial burst
module tb_univ_shift_reg_ser;
  logic clk = 0, reset_n = 0, en = 0, si = 0, so_ready = 0;
  logic [2:0] ctrl = 0, amt = 0;
  logic [7:0] d = 0, q;
  logic so, so_valid, busy, done;
  int total = 0, passed = 0, xfer = 0;
  string qn[$];
  logic [7:0] qv[$];
  logic ser_exp[$];

  univ_shift_reg_ser #(.N(8)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .ctrl(ctrl), .amt(amt), .si(si), .d(d),
    .q(q), .so(so), .so_valid(so_valid), .so_ready(so_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function void chk(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Monitor: drains pending q expectations and checks every accepted serial bit.
  always @(negedge clk) begin
    while (qn.size() > 0) chk(qn.pop_front(), q, qv.pop_front());
    if (so_valid && so_ready) begin
      xfer++;
      if (ser_exp.size() == 0) chk("ser_extra", 8'd1, 8'd0);
      else chk("so", {7'd0, so}, {7'd0, ser_exp.pop_front()});
    end
  end

  task automatic cmd(input logic [2:0] c, input logic [2:0] a, input logic s, input logic [7:0] dd);
    @(posedge clk); #1;
    en = 1; ctrl = c; amt = a; si = s; d = dd;
    @(posedge clk); #1;
    en = 0;
  endtask

  task automatic expect_q(input string n, input logic [7:0] v);
    qn.push_back(n);
    qv.push_back(v);
  endtask

  task automatic push_bits(input logic [7:0] v, input int cnt);
    for (int i = 0; i < cnt; i++) ser_exp.push_back(v[i]);
  endtask

  initial begin
    int bc, dc;
    #12;
    chk("rst_q", q, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_so_valid", {7'd0, so_valid}, 8'd0);
    chk("rst_so", {7'd0, so}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    @(posedge clk); #1; reset_n = 1;
    cmd(3'b110, 0, 0, 8'hA5); expect_q("load_a5", 8'hA5);
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; expect_q("hold", 8'hA5); end
    cmd(3'b110, 0, 0, 8'h81);
    cmd(3'b001, 3, 1, 0); expect_q("shl3_si1", 8'h0F);
    cmd(3'b010, 2, 0, 0); expect_q("shr2_si0", 8'h03);
    cmd(3'b110, 0, 0, 8'h81);
    cmd(3'b011, 3, 0, 0); expect_q("sar3", 8'hF0);
    cmd(3'b110, 0, 0, 8'h81);
    cmd(3'b100, 1, 0, 0); expect_q("rol1", 8'h03);
    cmd(3'b101, 1, 0, 0); expect_q("ror1", 8'h81);
    cmd(3'b100, 0, 0, 0); expect_q("rol0", 8'h81);
    cmd(3'b010, 0, 1, 0); expect_q("shr0", 8'h81);
    // Burst with so_ready high throughout.
    so_ready = 1; xfer = 0;
    push_bits(8'hB4, 8);
    cmd(3'b111, 0, 0, 8'hB4);
    bc = 0; dc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) dc++;
    end
    chk("burst_busy_cycles", 8'(bc), 8'd8);
    chk("burst_done_pulses", 8'(dc), 8'd1);
    chk("burst_xfers", 8'(xfer), 8'd8);
    @(posedge clk); #1; expect_q("burst_end_q", 8'h00);
    // Burst with stalls and an ignored LOAD.
    xfer = 0; dc = 0;
    push_bits(8'hFF, 8);
    cmd(3'b111, 0, 0, 8'hFF);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      so_ready = ~so_ready;
      en = (i == 3); ctrl = 3'b110; d = 8'h5A;
      if (done) dc++;
    end
    en = 0; so_ready = 1;
    chk("stall_xfers", 8'(xfer), 8'd8);
    chk("stall_done_pulses", 8'(dc), 8'd1);
    chk("stall_ser_q_empty", 8'(ser_exp.size()), 8'd0);
    @(posedge clk); #1; expect_q("stall_end_q", 8'h00);
    // Reset after three accepted bits.
    xfer = 0;
    push_bits(8'h2D, 3);
    cmd(3'b111, 0, 0, 8'h2D);
    repeat (3) @(posedge clk);
    #1; reset_n = 0; #1;
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_q", q, 8'h00);
    chk("abort_so_valid", {7'd0, so_valid}, 8'd0);
    repeat (2) @(posedge clk);
    #1; reset_n = 1;
    dc = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (done) dc++; end
    chk("abort_no_done", 8'(dc), 8'd0);
    chk("abort_xfers", 8'(xfer), 8'd3);
    chk("abort_ser_q_empty", 8'(ser_exp.size()), 8'd0);
    @(negedge clk); @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
